// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle for bit_serializer.
// Handshake: a word moves on a rising clk edge where din_valid && din_ready. din_valid
// must not wait for din_ready. Once raised, din and din_valid hold until that edge.
// din_ready may depend on en and rst in the same cycle.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             en;
  logic             j;
  logic             j_valid;
  logic             busy;

  modport master (
    output din, din_valid, en,
    input  din_ready, j, j_valid, busy
  );

  modport slave (
    input  din, din_valid, en,
    output din_ready, j, j_valid, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one bit per enabled clock on j. The default order is MSB first.
// Defining BIT_SERIALIZER_LSB_FIRST_EN switches the bit order to LSB first.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   bus,
  output logic [0:0]        state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    cnt;
  logic             jv_q;
  logic             last;
  logic             accept;

  // The bit on j is the head of sr. It is cleared when idle, so j reads 0 with no word loaded.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  assign bus.j      = sr[0];
  assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
`else
  assign bus.j      = sr[WIDTH-1];
  assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
`endif

  assign last          = (state == SHIFT) && (cnt == '0);
  // A reload is allowed only on the edge that retires the last bit. This avoids an idle bubble.
  assign bus.din_ready = rst && ((state == IDLE) || (last && bus.en));
  assign accept        = bus.din_valid && bus.din_ready;

  assign bus.j_valid = jv_q;
  assign bus.busy    = (state == SHIFT);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      jv_q  <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= bus.din;
      cnt   <= CW'(WIDTH - 1);
      jv_q  <= 1'b1;
    end else if (state == IDLE) begin
      jv_q  <= 1'b0;
    end else if (!bus.en) begin
      // A stalled bit stays on j but is not a new bit.
      jv_q  <= 1'b0;
    end else if (cnt != '0) begin
      sr    <= sr_shifted;
      cnt   <= cnt - 1'b1;
      jv_q  <= 1'b1;
    end else begin
      state <= IDLE;
      sr    <= '0;
      jv_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios followed by random traffic.
// Checks are made against a bit-position model and a word-level scoreboard.
module tb_bit_serializer;

  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();
  logic [0:0] state_dbg;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks which bit position of the current word is on j.
  logic             m_active = 1'b0;
  logic [WIDTH-1:0] m_word   = '0;
  int               m_pos    = 0;
  logic             m_j      = 1'b0;
  logic             m_jv     = 1'b0;

  function automatic logic bit_at(input logic [WIDTH-1:0] w, input int i);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] asm_w = '0;
  int               asm_n = 0;
  int               jv_run = 0;
  int               jv_max = 0;

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic dv, input logic [WIDTH-1:0] d,
                       input logic e, output logic acc);
    logic exp_ready;
    rst           = r;
    bus.din_valid = dv;
    bus.din       = d;
    bus.en        = e;
    #1;
    exp_ready = r && (!m_active || (m_pos == WIDTH-1 && e));
    acc       = dv && exp_ready;
    check("din_ready", 32'(bus.din_ready), 32'(exp_ready));
    @(posedge clk);
    if (!r) begin
      m_active = 1'b0; m_j = 1'b0; m_jv = 1'b0;
      exp_q.delete();
      asm_n = 0;
    end else if (acc) begin
      m_active = 1'b1; m_word = d; m_pos = 0;
      m_j = bit_at(d, 0); m_jv = 1'b1;
      exp_q.push_back(d);
    end else if (!m_active) begin
      m_j = 1'b0; m_jv = 1'b0;
    end else if (!e) begin
      m_jv = 1'b0;
    end else if (m_pos < WIDTH-1) begin
      m_pos++;
      m_j = bit_at(m_word, m_pos); m_jv = 1'b1;
    end else begin
      m_active = 1'b0; m_j = 1'b0; m_jv = 1'b0;
    end
    @(negedge clk);
    check("j",       32'(bus.j),       32'(m_j));
    check("j_valid", 32'(bus.j_valid), 32'(m_jv));
    check("busy",    32'(bus.busy),    32'(m_active));
    if (bus.j_valid) begin
      jv_run++;
      if (jv_run > jv_max) jv_max = jv_run;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      asm_w[asm_n] = bus.j;
`else
      asm_w[WIDTH-1-asm_n] = bus.j;
`endif
      asm_n++;
      if (asm_n == WIDTH) begin
        if (exp_q.size() == 0) check("sb_extra_word", 32'(asm_w), 32'hFFFF_FFFF);
        else check("sb_word", 32'(asm_w), 32'(exp_q.pop_front()));
        asm_n = 0;
      end
    end else begin
      jv_run = 0;
    end
  endtask

  task automatic idle_cycles(input int n, input logic e);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), e, a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    logic [WIDTH-1:0] words[2];
    int idx;

    rst = 1'b0; bus.din = '0; bus.din_valid = 1'b0; bus.en = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, 1'b1, 8'hAA, 1'b1, a);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, a);

    // Single word, continuous enable
    cycle(1'b1, 1'b1, 8'hB0, 1'b1, a);
    idle_cycles(WIDTH + 1, 1'b1);

    // Back-to-back words with din_valid held
    words[0] = 8'hB0; words[1] = 8'h5A; idx = 0; jv_max = 0;
    for (int t = 0; t < 40 && idx < 2; t++) begin
      cycle(1'b1, 1'b1, words[idx], 1'b1, a);
      if (a) idx++;
    end
    check("b2b_timeout", 32'(idx), 32'd2);
    idle_cycles(WIDTH + 1, 1'b1);
    check("b2b_run", 32'(jv_max), 32'(2*WIDTH));

    // Stall after the third bit
    cycle(1'b1, 1'b1, 8'hB0, 1'b1, a);
    idle_cycles(2, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b0, a);
    idle_cycles(WIDTH + 1, 1'b1);

    // Reset mid-word, then a fresh word
    cycle(1'b1, 1'b1, 8'hFF, 1'b1, a);
    idle_cycles(3, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, a);
    cycle(1'b1, 1'b1, 8'h01, 1'b1, a);
    idle_cycles(WIDTH + 1, 1'b1);

    // din_valid while busy: changing din must not disturb j
    cycle(1'b1, 1'b1, 8'hC3, 1'b1, a);
    for (int i = 0; i < WIDTH - 1; i++) cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b1, a);
    idle_cycles(2*WIDTH, 1'b1);

    // Random traffic
    for (int t = 0; t < 800; t++) begin
      cycle($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)), WIDTH'($urandom),
            $urandom_range(0, 3) != 0, a);
    end
    idle_cycles(2*WIDTH + 2, 1'b1);
    check("sb_pending_words", 32'(exp_q.size()), 32'd0);
    check("sb_partial_bits",  32'(asm_n),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock on `j`, the single-bit input the downstream Moore detector samples. `j_valid` marks cycles carrying a real data bit. Back-to-back words are serialised with no idle bubble.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  input  WIDTH  word to serialise; sampled on the accept edge only.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- en  input  1  bit strobe; shifting advances only on edges where en=1.
- j  output  1  registered serial data bit to the downstream detector.
- j_valid  output  1  registered; 1 when j carries a data bit.
- busy  output  1  registered; 1 while a word is loaded (state SHIFT).

## Operation
- States: IDLE, SHIFT. Internal: shift register `sr[WIDTH-1:0]` and bit counter `cnt`, ceil(log2(WIDTH)) bits.
- Combinational `din_ready`:
  - 1 when state=IDLE and rst=1.
  - 1 when state=SHIFT, cnt=0, en=1 and rst=1.
  - 0 otherwise, including every cycle with rst=0.
- Accept: `din_valid & din_ready` at a rising edge.
- IDLE:
  - On accept: load sr=din, set j=din[WIDTH-1], j_valid=1, cnt=WIDTH-1, go to SHIFT.
  - No accept: j=0, j_valid=0.
- SHIFT with en=1 and cnt>0: shift sr left by one, j=next bit, j_valid=1, cnt-=1.
- SHIFT with en=1 and cnt=0 (last bit on j this cycle):
  - On accept: reload from din exactly as on an IDLE accept, and stay in SHIFT.
  - No accept: go to IDLE with j=0, j_valid=0.
- SHIFT with en=0: sr, cnt, state and j hold; j_valid=0 for the next cycle. The held bit is not a new bit.
- Bit order is MSB first unless the configuration macro is defined (see Configuration).
- din is ignored on all edges that are not accept edges.
- busy=1 exactly when state=SHIFT.

## Timing
- Reset (rst=0 at an edge): state=IDLE, sr=0, cnt=0, j=0, j_valid=0, busy=0.
- Reset overrides everything, including a word in progress. The partial word is dropped and no further bits of it are emitted.
- Latency: a word accepted at edge k puts its first bit on j/j_valid after edge k. With en held at 1, bit i appears after edge k+i and the last bit after edge k+WIDTH-1.
- Throughput with en=1 continuous and din_valid=1: one word per WIDTH cycles, j_valid continuously 1.
- Simultaneous last bit and en=0: there is no accept. din_ready stays 0 until en=1 returns while cnt=0.
- din_valid asserted with din_ready=0: the word is not taken. The producer must hold din and din_valid until the accept.

## Configuration
- `BIT_SERIALIZER_LSB_FIRST_EN`
  - Defined: bit order is LSB first. j=din[0] on the first bit, sr shifts right, and the last bit is din[WIDTH-1].
  - Undefined (default): MSB first, as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset then single word: WIDTH=8, en=1, din=8'hB0 accepted at edge 1.
  - After edges 1..8, j=1,0,1,1,0,0,0,0 with j_valid=1 on all eight.
  - Then j_valid=0, busy=0, din_ready=1.
- Back-to-back: words 8'hB0 then 8'h5A with din_valid held 1.
  - Second word accepted on the edge that consumes the first word's last bit.
  - j_valid=1 for 16 consecutive cycles; bits 10110000 then 01011010.
- Stall: en=0 for 3 cycles after bit 2 of 8'hB0.
  - j holds 1 with j_valid=0 for 3 cycles.
  - The remaining bits 1,0,0,0,0 follow unchanged once en=1.
  - din_ready is never 1 during the stall.
- Reset mid-word: rst=0 at the edge after bit 3 of 8'hFF.
  - Next cycle: j=0, j_valid=0, busy=0.
  - A new word 8'h01 then emits 0,0,0,0,0,0,0,1.
- Handshake hold: din_valid=1 while busy with cnt>0.
  - din_ready=0; din changes on those cycles have no effect on j.
- LSB build with `BIT_SERIALIZER_LSB_FIRST_EN` defined: din=8'h0D gives j=1,0,1,1,0,0,0,0.
